mux_stage_reg: RTL and testbench

//  Parametrised N-way, W-bit operand/result select with one registered stage and valid/ready flow control.

---
 rtl/mux_stage_pkg.sv | 16 +
 rtl/mux_stage_reg_if.sv | 29 ++
 rtl/mux_sel_comb.sv | 36 +++
 rtl/mux_stage_reg.sv | 127 ++++++++++++
 tb/tb_mux_stage_reg.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_stage_pkg.sv
// Shared definitions for the registered mux stage.
//   state_e    : skid-buffer occupancy (EMPTY / ONE / TWO)
//   ERRCNT_W   : width of the optional bad-select counter
//   ERRCNT_MAX : saturation value of that counter
package mux_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int                   ERRCNT_W   = 16;
  localparam logic [ERRCNT_W-1:0]  ERRCNT_MAX = {ERRCNT_W{1'b1}};

endpackage

// File: rtl/mux_stage_reg_if.sv
// Handshake bundle for mux_stage_reg.
//   in_valid/in_ready/sel/data_in   : producer side (source i at [i*WIDTH +: WIDTH])
//   out_valid/out_ready/data_out/sel_err : consumer side
// master : the environment (producer + consumer)
// slave  : the stage itself
interface mux_stage_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    sel_err;

  modport master (
    output in_valid, sel, data_in, out_ready,
    input  in_ready, out_valid, data_out, sel_err
  );

  modport slave (
    input  in_valid, sel, data_in, out_ready,
    output in_ready, out_valid, data_out, sel_err
  );
endinterface

// File: rtl/mux_sel_comb.sv
// Pure combinational NUM_IN:1 select.
//   sel      : source index
//   data_in  : packed sources, source i at [i*WIDTH +: WIDTH]
//   data_out : selected source, zero when sel >= NUM_IN
//   err      : sel >= NUM_IN
module mux_sel_comb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    err
);

  logic [NUM_IN-1:0][WIDTH-1:0] src;
  logic [NUM_IN-1:0]            hit;

  assign src = data_in;

  // One-hot decode; an out-of-range sel hits nothing, which yields the zero
  // default from the AND-OR tree and flags the error for free.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_hit
    assign hit[i] = (sel == SEL_W'(i));
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_IN; i++)
      data_out = data_out | (src[i] & {WIDTH{hit[i]}});
  end

  assign err = ~|hit;

endmodule

// File: rtl/mux_stage_reg.sv
// N-way W-bit select with one registered stage and a 2-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_stage_reg_if.slave (in_valid/in_ready/sel/data_in,
//                out_valid/out_ready/data_out/sel_err)
//   err_count  : saturating count of accepted beats with sel >= NUM_IN,
//                present only when MUX_STAGE_ERRCNT_EN is defined
// in_ready depends only on registered state, so out_ready never reaches it
// combinationally.
module mux_stage_reg
  import mux_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_stage_reg_if.slave   bus
`ifdef MUX_STAGE_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam int SEL_W = $clog2(NUM_IN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, skid_data_q, mux_data;
  logic             main_err_q, skid_err_q, mux_err;
  logic             skid_valid;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel      (bus.sel),
    .data_in  (bus.data_in),
    .data_out (mux_data),
    .err      (mux_err)
  );

  assign skid_valid    = (state_q == TWO);
  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.data_out  = main_data_q;
  assign bus.sel_err   = main_err_q;

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end
      end
      TWO: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_err_q  <= 1'b0;
    end else if (load_main_in) begin
      main_data_q <= mux_data;
      main_err_q  <= mux_err;
    end else if (load_main_skid) begin
      main_data_q <= skid_data_q;
      main_err_q  <= skid_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else if (load_skid) begin
      skid_data_q <= mux_data;
      skid_err_q  <= mux_err;
    end
  end

`ifdef MUX_STAGE_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (in_fire && mux_err && (err_cnt_q != ERRCNT_MAX))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_stage_reg.sv
// Bench for mux_stage_reg: a 4-input instance for streaming/backpressure/hold
// and a 3-input instance for out-of-range selects and randomized traffic
// scored against a queue model. Inputs change on the falling edge; registered
// outputs are observed there too.
module tb_mux_stage_reg;
  import mux_stage_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mux_stage_reg_if #(.WIDTH(W), .NUM_IN(4)) if4 ();
  mux_stage_reg_if #(.WIDTH(W), .NUM_IN(3)) if3 ();

`ifdef MUX_STAGE_ERRCNT_EN
  logic [ERRCNT_W-1:0] err4, err3;
  mux_stage_reg #(.WIDTH(W), .NUM_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .err_count(err4));
  mux_stage_reg #(.WIDTH(W), .NUM_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .err_count(err3));
`else
  mux_stage_reg #(.WIDTH(W), .NUM_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  mux_stage_reg #(.WIDTH(W), .NUM_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
`endif

  task automatic test_reset();
    logic [W-1:0] v;
    #3;
    n_chk++; if (if4.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", if4.out_valid); else n_pass++;
    n_chk++; if (if4.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", if4.in_ready); else n_pass++;
    n_chk++; if (if4.data_out !== '0) $display("FAIL rst_data_out got %h want 0", if4.data_out); else n_pass++;
    n_chk++; if (if4.sel_err !== 1'b0) $display("FAIL rst_sel_err got %b want 0", if4.sel_err); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Fill both entries, then reset asynchronously mid-stream.
    v = $urandom;
    if4.data_in = {4{v}}; if4.sel = 2'd1; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    if4.in_valid = 1'b0;
    n_chk++; if (if4.in_ready !== 1'b0) $display("FAIL rst_prefill_in_ready got %b want 0", if4.in_ready); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (if4.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", if4.out_valid); else n_pass++;
    n_chk++; if (if4.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", if4.in_ready); else n_pass++;
    n_chk++; if (if4.data_out !== '0) $display("FAIL rst_mid_data_out got %h want 0", if4.data_out); else n_pass++;
    n_chk++; if (if4.sel_err !== 1'b0) $display("FAIL rst_mid_sel_err got %b want 0", if4.sel_err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    if4.data_in = {vals[3], vals[2], vals[1], vals[0]};
    if4.out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_chk++; if (if4.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", k, if4.in_ready); else n_pass++;
      if (k > 0) begin
        n_chk++; if (if4.out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", k, if4.out_valid); else n_pass++;
        n_chk++; if (if4.data_out !== vals[k-1]) $display("FAIL stream_data[%0d] got %h want %h", k, if4.data_out, vals[k-1]); else n_pass++;
      end
      if4.in_valid = (k < 4);
      if4.sel = 2'(k);
    end
    @(negedge clk);
    n_chk++; if (if4.out_valid !== 1'b0) $display("FAIL stream_drained got %b want 0", if4.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    if4.data_in = {vals[3], vals[2], vals[1], vals[0]};
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1; if4.sel = 2'd0;           // beat A
    @(negedge clk);
    n_chk++; if (if4.in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", if4.in_ready); else n_pass++;
    if4.sel = 2'd1;                                 // beat B -> skid
    @(negedge clk);
    n_chk++; if (if4.in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", if4.in_ready); else n_pass++;
    if4.sel = 2'd2;                                 // beat C offered, must wait
    @(negedge clk);
    n_chk++; if (if4.in_ready !== 1'b0) $display("FAIL bp_full2 got %b want 0", if4.in_ready); else n_pass++;
    n_chk++; if (if4.data_out !== vals[0]) $display("FAIL bp_head got %h want %h", if4.data_out, vals[0]); else n_pass++;
    if4.out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (if4.data_out !== vals[1]) $display("FAIL bp_drain_b got %h want %h", if4.data_out, vals[1]); else n_pass++;
    n_chk++; if (if4.in_ready !== 1'b1) $display("FAIL bp_reopen got %b want 1", if4.in_ready); else n_pass++;
    @(negedge clk);
    if4.in_valid = 1'b0;
    n_chk++; if (if4.data_out !== vals[2]) $display("FAIL bp_drain_c got %h want %h", if4.data_out, vals[2]); else n_pass++;
    n_chk++; if (if4.out_valid !== 1'b1) $display("FAIL bp_valid_c got %b want 1", if4.out_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (if4.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", if4.out_valid); else n_pass++;
  endtask

  task automatic test_hold();
    logic [W-1:0] v;
    v = $urandom;
    if4.data_in = {32'h0, v, 32'h0, 32'h0};
    if4.sel = 2'd2; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
    @(negedge clk);
    if4.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if4.data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_chk++; if (if4.data_out !== v) $display("FAIL hold_data[%0d] got %h want %h", k, if4.data_out, v); else n_pass++;
      n_chk++; if (if4.out_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", k, if4.out_valid); else n_pass++;
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (if4.out_valid !== 1'b0) $display("FAIL hold_release got %b want 0", if4.out_valid); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] vals [3];
    for (int i = 0; i < 3; i++) vals[i] = $urandom | 32'h1;
    if3.data_in = {vals[2], vals[1], vals[0]};
    if3.out_ready = 1'b1; if3.in_valid = 1'b1; if3.sel = 2'd3;
    @(negedge clk);
    n_chk++; if (if3.data_out !== '0) $display("FAIL oor_data got %h want 0", if3.data_out); else n_pass++;
    n_chk++; if (if3.sel_err !== 1'b1) $display("FAIL oor_err got %b want 1", if3.sel_err); else n_pass++;
    if3.sel = 2'd1;
    @(negedge clk);
    n_chk++; if (if3.data_out !== vals[1]) $display("FAIL oor_next_data got %h want %h", if3.data_out, vals[1]); else n_pass++;
    n_chk++; if (if3.sel_err !== 1'b0) $display("FAIL oor_next_err got %b want 0", if3.sel_err); else n_pass++;
    if3.sel = 2'd2;
    @(negedge clk);
    n_chk++; if (if3.data_out !== vals[2]) $display("FAIL oor_top_data got %h want %h", if3.data_out, vals[2]); else n_pass++;
    n_chk++; if (if3.sel_err !== 1'b0) $display("FAIL oor_top_err got %b want 0", if3.sel_err); else n_pass++;
    if3.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Random traffic on the 3-input stage; the model is just a FIFO of the
  // values a correct stage must emit, capacity two.
  task automatic test_random();
    logic [W:0]      q [$];
    logic [W:0]      exp_b;
    logic [3*W-1:0]  d;
    int              s;
    logic            held, fire_in;
    held = 1'b0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_chk++; if (if3.out_valid !== (q.size() != 0)) $display("FAIL rnd_valid[%0d] got %b want %b", c, if3.out_valid, q.size() != 0); else n_pass++;
      n_chk++; if (if3.in_ready !== (q.size() < 2)) $display("FAIL rnd_ready[%0d] got %b want %b", c, if3.in_ready, q.size() < 2); else n_pass++;
      if (q.size() != 0) begin
        n_chk++; if ({if3.sel_err, if3.data_out} !== q[0]) $display("FAIL rnd_beat[%0d] got %b/%h want %b/%h", c, if3.sel_err, if3.data_out, q[0][W], q[0][W-1:0]); else n_pass++;
      end
      if (!held) begin
        if3.in_valid = (c < 580) && ($urandom_range(0, 9) < 7);
        if3.sel = 2'($urandom_range(0, 3));
        if3.data_in = {$urandom, $urandom, $urandom};
      end
      if3.out_ready = (c >= 580) || ($urandom_range(0, 9) < 6);
      d = if3.data_in;
      s = int'(if3.sel);
      exp_b = (s < 3) ? {1'b0, d[s*W +: W]} : {1'b1, {W{1'b0}}};
      fire_in = if3.in_valid && (q.size() < 2);
      if (if3.out_ready && q.size() != 0) void'(q.pop_front());
      if (fire_in) q.push_back(exp_b);
      held = if3.in_valid && !fire_in;
    end
    @(negedge clk);
    n_chk++; if (q.size() != 0 || if3.out_valid !== 1'b0) $display("FAIL rnd_final got valid=%b want 0 (model %0d left)", if3.out_valid, q.size()); else n_pass++;
    if3.in_valid = 1'b0;
  endtask

`ifdef MUX_STAGE_ERRCNT_EN
  task automatic test_err_count();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_chk++; if (err3 !== 16'd0) $display("FAIL errcnt_reset got %0d want 0", err3); else n_pass++;
    if3.out_ready = 1'b1; if3.in_valid = 1'b1; if3.sel = 2'd3;
    repeat (5) @(negedge clk);
    if3.sel = 2'd0;
    @(negedge clk);
    if3.in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (err3 !== 16'd5) $display("FAIL errcnt_five got %0d want 5", err3); else n_pass++;
    force dut3.err_cnt_q = ERRCNT_MAX;
    #1 release dut3.err_cnt_q;
    if3.in_valid = 1'b1; if3.sel = 2'd3;
    @(negedge clk);
    if3.in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (err3 !== 16'hFFFF) $display("FAIL errcnt_sat got %h want ffff", err3); else n_pass++;
  endtask
`endif

  initial begin
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.sel = '0; if4.data_in = '0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b0; if3.sel = '0; if3.data_in = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_out_of_range();
    test_random();
`ifdef MUX_STAGE_ERRCNT_EN
    test_err_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
